// File: rtl/pipelinediv_core.sv
// rtl/pipelinediv_core.sv - fully pipelined restoring divider, one quotient bit per stage
// Optional feature: define PIPELINEDIV_DBZ_FLAG_EN to add the div_by_zero output.
module pipelinediv_core #(
  parameter int DIVIDEND = 4,
  parameter int DIVISOR  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder
`ifdef PIPELINEDIV_DBZ_FLAG_EN
  ,
  output logic                div_by_zero
`endif
);

  localparam int N = DIVIDEND;
  localparam int M = DIVISOR;

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic         up_vld;
    logic [M-1:0] up_dsr;
    logic [N-1:0] up_dvd;
    logic [M-1:0] up_rem;
    logic [N-1:0] up_quo;
    logic [M:0]   trial;
    logic         fits;
    logic [M-1:0] rem_q;
    logic [N-1:0] quo_q;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
    logic         up_dbz;
    logic         dbz_q;
`endif

    if (s == 0) begin : g_in
      assign up_vld = 1'b1;
      assign up_dsr = divisor;
      assign up_dvd = dividend;
      assign up_rem = '0;
      assign up_quo = '0;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
      assign up_dbz = (divisor == '0);
`endif
    end else begin : g_link
      assign up_vld = g_stage[s-1].g_carry.vld_q;
      assign up_dsr = g_stage[s-1].g_carry.dsr_q;
      assign up_dvd = g_stage[s-1].g_carry.dvd_q;
      assign up_rem = g_stage[s-1].rem_q;
      assign up_quo = g_stage[s-1].quo_q;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
      assign up_dbz = g_stage[s-1].dbz_q;
`endif
    end

    // Compare is M+1 bits wide; a zero divisor always "fits", giving all-ones
    // quotient and leaving the low dividend bits as the remainder.
    assign trial = {up_rem, up_dvd[N-1]};
    assign fits  = (trial >= {1'b0, up_dsr});

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rem_q <= '0;
        quo_q <= '0;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
        dbz_q <= 1'b0;
`endif
      end else if (up_vld) begin
        rem_q <= fits ? (trial[M-1:0] - up_dsr) : trial[M-1:0];
        quo_q <= (up_quo << 1) | N'(fits);
`ifdef PIPELINEDIV_DBZ_FLAG_EN
        dbz_q <= up_dbz;
`endif
      end else begin
        rem_q <= '0;
        quo_q <= '0;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
        dbz_q <= 1'b0;
`endif
      end
    end

    // The output stage needs no occupancy, divisor or remaining dividend bits.
    if (s < N - 1) begin : g_carry
      logic         vld_q;
      logic [M-1:0] dsr_q;
      logic [N-1:0] dvd_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= 1'b0;
          dsr_q <= '0;
          dvd_q <= '0;
        end else begin
          vld_q <= up_vld;
          dsr_q <= up_vld ? up_dsr : '0;
          dvd_q <= up_vld ? (up_dvd << 1) : '0;
        end
      end
    end
  end

  assign quotient  = g_stage[N-1].quo_q;
  assign remainder = g_stage[N-1].rem_q;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
  assign div_by_zero = g_stage[N-1].dbz_q;
`endif

endmodule

// File: tb/tb_pipelinediv_core.sv
// tb/tb_pipelinediv_core.sv - self-checking bench for pipelinediv_core (DIVIDEND=4, DIVISOR=2)
module tb_pipelinediv_core;
  localparam int N = 4;
  localparam int M = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
`ifdef PIPELINEDIV_DBZ_FLAG_EN
  logic         div_by_zero;
`endif

  always #5 clock = ~clock;

  pipelinediv_core #(.DIVIDEND(N), .DIVISOR(M)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder)
`ifdef PIPELINEDIV_DBZ_FLAG_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         z;
  } res_t;

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
  } vec_t;

  res_t pend[$];
  res_t zero_res = '{q: '0, r: '0, z: 1'b0};
  int   compared = 0;
  int   mismatched = 0;

  function automatic res_t model(input logic [N-1:0] a, input logic [M-1:0] b);
    res_t x;
    int   ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      x.q = {N{1'b1}};
      x.r = M'(ai % (1 << M));
      x.z = 1'b1;
    end else begin
      x.q = N'(ai / bi);
      x.r = M'(ai - (ai / bi) * bi);
      x.z = 1'b0;
    end
    return x;
  endfunction

  task automatic check(input string name, input res_t e);
    compared++;
    if (quotient !== e.q || remainder !== e.r) begin
      mismatched++;
      $display("FAIL %s: got q=%0d r=%0d, want q=%0d r=%0d (t=%0t)",
               name, quotient, remainder, e.q, e.r, $time);
    end
`ifdef PIPELINEDIV_DBZ_FLAG_EN
    compared++;
    if (div_by_zero !== e.z) begin
      mismatched++;
      $display("FAIL %s_dbz: got %0b, want %0b (t=%0t)", name, div_by_zero, e.z, $time);
    end
`endif
  endtask

  // One cycle: drive at negedge, capture on posedge, check at the next negedge.
  task automatic cyc(input string name, input logic [N-1:0] a, input logic [M-1:0] b,
                     input res_t e);
    dividend = a;
    divisor  = b;
    @(posedge clock);
    if (reset_n) pend.push_back(e);
    @(negedge clock);
    if (pend.size() >= N) check(name, pend.pop_front());
    else check({name, "_idle"}, zero_res);
  endtask

  task automatic feed(input string name, input logic [N-1:0] a, input logic [M-1:0] b);
    cyc(name, a, b, model(a, b));
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{a: 4'd13, b: 2'd3, q: 4'd4,  r: 2'd1};
    tbl[1] = '{a: 4'd15, b: 2'd1, q: 4'd15, r: 2'd0};
    tbl[2] = '{a: 4'd2,  b: 2'd3, q: 4'd0,  r: 2'd2};
    tbl[3] = '{a: 4'd8,  b: 2'd2, q: 4'd4,  r: 2'd0};
    tbl[4] = '{a: 4'd9,  b: 2'd0, q: 4'd15, r: 2'd1};
    tbl[5] = '{a: 4'd0,  b: 2'd1, q: 4'd0,  r: 2'd0};
    tbl[6] = '{a: 4'd7,  b: 2'd2, q: 4'd3,  r: 2'd1};
    tbl[7] = '{a: 4'd15, b: 2'd3, q: 4'd5,  r: 2'd0};

    dividend = 4'd13;
    divisor  = 2'd3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", zero_res);
    reset_n = 1'b1;

    // Table runs straight after reset: first entry (13/3) must not show early.
    for (int i = 0; i < 8; i++)
      cyc("table", tbl[i].a, tbl[i].b,
          '{q: tbl[i].q, r: tbl[i].r, z: (tbl[i].b == '0)});

    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++)
        feed("sweep", N'(a), M'(b));

    for (int i = 0; i < 200; i++)
      feed("random", N'($urandom_range(15)), M'($urandom_range(3)));

    // Keep the pipe full of nonzero results, then reset with ops in flight.
    for (int i = 0; i < 6; i++) feed("pre_reset", 4'd15, 2'd1);
    #2 reset_n = 1'b0;
    #1 check("reset_async", zero_res);
    pend.delete();
    @(negedge clock);
    check("reset_hold", zero_res);
    cyc("reset_low", 4'd14, 2'd3, zero_res);
    reset_n = 1'b1;

    feed("post_reset", 4'd11, 2'd2);
    for (int i = 0; i < 5; i++)
      feed("post_reset", N'($urandom_range(15)), M'($urandom_range(3)));
    for (int i = 0; i < N; i++) feed("drain", 4'd0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach end, compared=%0d", compared);
    $fatal(1);
  end
endmodule

// File: doc/pipelinediv_core.md
PIPELINEDIV_CORE -- requirements
Module: pipelinediv

Interface
REQ-001 Parameter DIVIDEND, default 4: dividend and quotient width in bits; SHALL be >= 2.
REQ-002 Parameter DIVISOR, default 2: divisor and remainder width in bits; SHALL satisfy 1 <= DIVISOR <= DIVIDEND.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port `clock`, input, 1 bit: sole clock, rising-edge active.
REQ-005 Port `reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port `dividend`, input, DIVIDEND bits: unsigned dividend, sampled every rising edge.
REQ-007 Port `divisor`, input, DIVISOR bits: unsigned divisor, sampled every rising edge.
REQ-008 Port `quotient`, output, DIVIDEND bits: registered unsigned quotient.
REQ-009 Port `remainder`, output, DIVISOR bits: registered unsigned remainder.

Function
REQ-010 The divider SHALL be fully pipelined restoring division, one quotient bit per stage, MSB first, DIVIDEND register stages, and SHALL accept a new operand pair every cycle with no handshake.
REQ-011 Stage 1 SHALL be fed combinationally from the input ports; each stage SHALL carry divisor, remaining dividend bits, partial remainder and quotient bits forward.
REQ-012 Operands present at rising edge k SHALL appear on quotient/remainder immediately after rising edge k+DIVIDEND-1, and hold for exactly one cycle (latency = DIVIDEND edges, including the capture edge).
REQ-013 For divisor != 0: quotient = floor(dividend/divisor); remainder = dividend - quotient*divisor, always < divisor and representable in DIVISOR bits.
REQ-014 Partial-remainder datapath SHALL be DIVISOR+1 bits wide, so the compare/subtract cannot overflow.
REQ-015 Divide by zero: quotient SHALL be all ones; remainder SHALL be dividend[DIVISOR-1:0].
REQ-016 Back-to-back operands SHALL never interfere; each result depends only on its own operand pair.
REQ-017 There SHALL be no combinational path from inputs to outputs.

Reset
REQ-018 While reset_n is low, all stage registers and the outputs SHALL be cleared to 0 asynchronously.
REQ-019 Each stage SHALL hold an occupancy bit, cleared by reset; outputs SHALL stay 0 until the first operand pair captured after reset release reaches the output stage.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight operations; no pre-reset result SHALL appear after release.
REQ-021 The first rising edge with reset_n high SHALL capture operands normally.

Configuration
REQ-022 With macro PIPELINEDIV_DBZ_FLAG_EN defined, the block SHALL add output port `div_by_zero` (1 bit), high in the same cycle as the result of a zero-divisor operation, low otherwise, and 0 in reset.
REQ-023 Without PIPELINEDIV_DBZ_FLAG_EN, the port and its pipeline bit SHALL not exist; all other behaviour SHALL be identical.

Verification (DIVIDEND=4, DIVISOR=2)
REQ-024 Apply 13/3 at edge k -> quotient 4, remainder 1 after edge k+3, not earlier.
REQ-025 Apply 15/1, 2/3, 8/2 on consecutive edges -> results (15,0), (2... no: 0,2), (4,0) on three consecutive cycles starting 3 edges later.
REQ-026 Apply 9/0 -> quotient 15, remainder 1; div_by_zero = 1 only when the macro is defined.
REQ-027 Sweep all 64 {divisor,dividend} combinations, one per cycle -> every nonzero-divisor result matches the REQ-013 definition exactly 3 edges after capture.
REQ-028 Assert reset_n low with 3 operations in flight -> outputs 0 immediately; after release, outputs stay 0 until the first new operand's result appears 3 edges after its capture.
